// File: rtl/tmds_decoder.sv
// TMDS receive channel decoder: word alignment search, lock tracking,
// and 10b->8b symbol decode with control-token detection.
module tmds_decoder #(
  parameter int LOCK_COUNT    = 16,
  parameter int SEARCH_WINDOW = 2048,
  parameter int LOSS_TIMEOUT  = 4096,
  parameter int CNT_W         = 13
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] raw_in,
  output logic [7:0] data,
  output logic [1:0] c,
  output logic       de,
  output logic       locked,
  output logic [3:0] bit_offset
);

  localparam logic [0:0] S_SEARCH = 1'b0;
  localparam logic [0:0] S_LOCKED = 1'b1;

  localparam logic [9:0] TOK0 = 10'b1101010100;
  localparam logic [9:0] TOK1 = 10'b0010101011;
  localparam logic [9:0] TOK2 = 10'b0101010100;
  localparam logic [9:0] TOK3 = 10'b1010101011;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] LOCK_N   = CNT_W'(LOCK_COUNT);
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(SEARCH_WINDOW - 1);
  localparam logic [CNT_W-1:0] LOSS_N   = CNT_W'(LOSS_TIMEOUT);

  logic [9:0]       raw_d1_q;
  logic [9:0]       sym_q, sym_d;
  logic [0:0]       state_q, state_d;
  logic [3:0]       off_q, off_d;
  logic [CNT_W-1:0] tok_run_q, tok_run_d;
  logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             hold_q, hold_d;
  logic [7:0]       data_q, data_d;
  logic [1:0]       c_q, c_d;
  logic             de_q, de_d;
  logic             locked_q;

  logic       is_tok;
  logic       tok_seen;
  logic [1:0] tok_c;
  logic [7:0] dword;
  logic [7:0] dec;
  logic [19:0] win;

  // Select the 10-bit symbol at the current offset from two adjacent words
  always_comb begin
    win   = {raw_in, raw_d1_q};
    sym_d = 10'(win >> off_q);
  end

  // Recognise the four control tokens on the aligned symbol
  always_comb begin
    is_tok = 1'b1;
    tok_c  = 2'b00;
    unique case (1'b1)
      (sym_q == TOK0): tok_c = 2'b00;
      (sym_q == TOK1): tok_c = 2'b01;
      (sym_q == TOK2): tok_c = 2'b10;
      (sym_q == TOK3): tok_c = 2'b11;
      default:         is_tok = 1'b0;
    endcase
  end

  // Undo the optional inversion, then the XOR/XNOR chain
  always_comb begin
    dword  = sym_q[9] ? ~sym_q[7:0] : sym_q[7:0];
    dec    = '0;
    dec[0] = dword[0];
    for (int i = 1; i < 8; i++) begin
      dec[i] = sym_q[8] ? (dword[i] ^ dword[i-1])
                        : ~(dword[i] ^ dword[i-1]);
    end
  end

  // Alignment search and lock supervision
  always_comb begin
    state_d   = state_q;
    off_d     = off_q;
    tok_run_d = tok_run_q;
    win_cnt_d = win_cnt_q;
    gap_cnt_d = gap_cnt_q;
    hold_d    = 1'b0;
    tok_seen  = is_tok & ~hold_q;
    unique case (state_q)
      S_SEARCH: begin
        if (!tok_seen)
          tok_run_d = '0;
        else if (tok_run_q != CNT_MAX)
          tok_run_d = tok_run_q + 1'b1;
        if (win_cnt_q != CNT_MAX)
          win_cnt_d = win_cnt_q + 1'b1;
        if (tok_run_d >= LOCK_N) begin
          state_d   = S_LOCKED;
          tok_run_d = '0;
          win_cnt_d = '0;
          gap_cnt_d = '0;
        end else if (win_cnt_q >= WIN_LAST) begin
          off_d     = (off_q == 4'd9) ? 4'd0 : off_q + 4'd1;
          tok_run_d = '0;
          win_cnt_d = '0;
          hold_d    = 1'b1;
        end
      end
      default: begin
        if (is_tok)
          gap_cnt_d = '0;
        else if (gap_cnt_q != CNT_MAX)
          gap_cnt_d = gap_cnt_q + 1'b1;
        if (gap_cnt_d >= LOSS_N) begin
          state_d   = S_SEARCH;
          gap_cnt_d = '0;
          tok_run_d = '0;
          win_cnt_d = '0;
        end
      end
    endcase
  end

  // Next output values; forced to zero whenever not locked
  always_comb begin
    data_d = '0;
    c_d    = '0;
    de_d   = 1'b0;
    if (state_d == S_LOCKED) begin
      if (is_tok) begin
        data_d = data_q;
        c_d    = tok_c;
      end else begin
        data_d = dec;
        c_d    = c_q;
        de_d   = 1'b1;
      end
    end
  end

  // Pipeline, FSM and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      raw_d1_q  <= '0;
      sym_q     <= '0;
      state_q   <= S_SEARCH;
      off_q     <= '0;
      tok_run_q <= '0;
      win_cnt_q <= '0;
      gap_cnt_q <= '0;
      hold_q    <= 1'b0;
      data_q    <= '0;
      c_q       <= '0;
      de_q      <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      raw_d1_q  <= raw_in;
      sym_q     <= sym_d;
      state_q   <= state_d;
      off_q     <= off_d;
      tok_run_q <= tok_run_d;
      win_cnt_q <= win_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      hold_q    <= hold_d;
      data_q    <= data_d;
      c_q       <= c_d;
      de_q      <= de_d;
      locked_q  <= (state_d == S_LOCKED);
    end
  end

  assign data       = data_q;
  assign c          = c_q;
  assign de         = de_q;
  assign locked     = locked_q;
  assign bit_offset = off_q;

endmodule

// File: tb/tb_tmds_decoder.sv
// Randomized bench for tmds_decoder: encoder-inverse data model,
// window-level lock prediction and a 3-deep output scoreboard.
module tb_tmds_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [9:0] raw_in = '0;
  logic [7:0] data;
  logic [1:0] c;
  logic       de;
  logic       locked;
  logic [3:0] bit_offset;

  always #5 clk = ~clk;

  tmds_decoder dut (
    .clk       (clk),
    .reset     (reset),
    .raw_in    (raw_in),
    .data      (data),
    .c         (c),
    .de        (de),
    .locked    (locked),
    .bit_offset(bit_offset)
  );

  localparam logic [9:0] T0 = 10'b1101010100;
  localparam logic [9:0] T1 = 10'b0010101011;
  localparam logic [9:0] T2 = 10'b0101010100;
  localparam logic [9:0] T3 = 10'b1010101011;
  localparam logic [9:0] D00 = 10'b0100000000;
  localparam logic [9:0] DFF = 10'b1000000000;

  int n_chk = 0;
  int n_fail = 0;
  int skew = 0;
  logic [9:0] prev_sym = '0;
  logic [7:0] last_d = '0;
  logic [1:0] last_c = '0;
  logic [11:0] sbq[$];
  logic [9:0] sched[$];
  logic [7:0] schedb[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // {valid, c} for a control token
  function automatic logic [2:0] tok_code(input logic [9:0] s);
    if (s == T0) return 3'b100;
    if (s == T1) return 3'b101;
    if (s == T2) return 3'b110;
    if (s == T3) return 3'b111;
    return 3'b000;
  endfunction

  // Transmit-side transition-minimisation stage plus optional inversion
  function automatic logic [9:0] enc(input logic [7:0] d,
                                     input logic xm, input logic inv);
    logic [7:0] qm;
    qm[0] = d[0];
    for (int i = 1; i < 8; i++)
      qm[i] = xm ? (qm[i-1] ^ d[i]) : ~(qm[i-1] ^ d[i]);
    return {inv, xm, inv ? ~qm : qm};
  endfunction

  task automatic rnd_data(output logic [9:0] s, output logic [7:0] d);
    logic [2:0] tc;
    do begin
      d  = 8'($urandom);
      s  = enc(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tc = tok_code(s);
    end while (tc[2]);
  endtask

  task automatic rnd_sym(output logic [9:0] s, output logic [7:0] d);
    int k;
    k = $urandom_range(0, 7);
    d = '0;
    case (k)
      0: s = T0;
      1: s = T1;
      2: s = T2;
      3: s = T3;
      default: rnd_data(s, d);
    endcase
  endtask

  // One word per clock; checks the output due for the symbol 3 steps back
  task automatic step(input logic [9:0] sym, input logic lk,
                      input logic [7:0] db);
    logic [19:0] pair;
    logic [2:0]  tc;
    logic [11:0] e;
    if (sbq.size() == 3) begin
      e = sbq.pop_front();
      chk("out", 32'({locked, de, c, data}), 32'(e));
    end
    tc = tok_code(sym);
    if (!lk) begin
      last_d = '0;
      last_c = '0;
      e = '0;
    end else if (tc[2]) begin
      last_c = tc[1:0];
      e = {1'b1, 1'b0, last_c, last_d};
    end else begin
      last_d = db;
      e = {1'b1, 1'b1, last_c, last_d};
    end
    sbq.push_back(e);
    pair = {sym, prev_sym};
    raw_in = 10'(pair >> (10 - skew));
    prev_sym = sym;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    raw_in = '0;
    prev_sym = '0;
    last_d = '0;
    last_c = '0;
    sbq.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  // Window-level lock prediction: offset w%10 is tried for 2048 clocks,
  // the first clock after a move is blind, 16 aligned tokens in a row lock.
  function automatic int predict_lock(input int sk);
    int run;
    int w;
    int ph;
    int j;
    logic tk;
    logic [2:0] tc;
    run = 0;
    for (int e = 0; e < sched.size() + 2; e++) begin
      w  = e / 2048;
      ph = e % 2048;
      j  = e - 2;
      if (w > 0 && ph == 0) begin
        run = 0;
      end else begin
        tk = 1'b0;
        if ((w % 10) == sk && j >= 0) begin
          tc = tok_code(sched[j]);
          tk = tc[2];
        end
        run = tk ? run + 1 : 0;
        if (run >= 16) return j;
        if (ph == 2047) run = 0;
      end
    end
    return -1;
  endfunction

  task automatic play_sched(input int lockj);
    for (int j = 0; j < sched.size(); j++)
      step(sched[j], (lockj >= 0) && (j >= lockj), schedb[j]);
  endtask

  task automatic add_line();
    for (int i = 0; i < 160; i++) begin
      sched.push_back(T0);
      schedb.push_back(8'h00);
    end
    for (int i = 0; i < 640; i++) begin
      sched.push_back(i[0] ? DFF : D00);
      schedb.push_back(i[0] ? 8'hFF : 8'h00);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] s;
    logic [7:0] d;
    int lockj;

    #1 reset = 1'b1;
    #1;
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_c", 32'(c), 32'd0);
    chk("rst_de", 32'(de), 32'd0);
    chk("rst_lock", 32'(locked), 32'd0);
    chk("rst_off", 32'(bit_offset), 32'd0);

    // Aligned stream: lock, known bytes, then random tokens/data
    skew = 0;
    do_reset();
    sched.delete();
    schedb.delete();
    for (int i = 0; i < 160; i++) begin
      sched.push_back(T0);
      schedb.push_back(8'h00);
    end
    sched.push_back(D00); schedb.push_back(8'h00);
    sched.push_back(DFF); schedb.push_back(8'hFF);
    lockj = predict_lock(0);
    play_sched(lockj);
    chk("off_a", 32'(bit_offset), 32'd0);
    step(T1, 1'b1, 8'h00);
    step(T2, 1'b1, 8'h00);
    step(T3, 1'b1, 8'h00);
    for (int i = 0; i < 300; i++) begin
      rnd_sym(s, d);
      step(s, 1'b1, d);
    end

    // 3-bit skew with 800-clock lines: search must walk to offset 3
    skew = 3;
    do_reset();
    sched.delete();
    schedb.delete();
    for (int l = 0; l < 9; l++) add_line();
    lockj = predict_lock(3);
    play_sched(lockj);
    chk("off_skew", 32'(bit_offset), 32'd3);
    chk("lock_skew", 32'(locked), 32'd1);

    // Loss of tokens drops lock, tokens again relock at the same offset
    for (int i = 0; i < 8; i++) step(T0, 1'b1, 8'h00);
    for (int m = 1; m <= 4100; m++) begin
      rnd_data(s, d);
      step(s, m < 4096, d);
    end
    for (int u = 0; u < 40; u++) step(T0, u >= 15, 8'h00);
    chk("off_relock", 32'(bit_offset), 32'd3);
    for (int i = 0; i < 60; i++) begin
      rnd_sym(s, d);
      step(s, 1'b1, d);
    end
    rnd_data(s, d);
    step(s, 1'b1, d);

    // Asynchronous reset between clock edges while locked
    #2 reset = 1'b1;
    #1;
    chk("arst_data", 32'(data), 32'd0);
    chk("arst_c", 32'(c), 32'd0);
    chk("arst_de", 32'(de), 32'd0);
    chk("arst_lock", 32'(locked), 32'd0);
    chk("arst_off", 32'(bit_offset), 32'd0);
    skew = 0;
    do_reset();
    for (int u = 0; u < 40; u++) step(T0, u >= 15, 8'h00);
    for (int i = 0; i < 30; i++) begin
      rnd_sym(s, d);
      step(s, 1'b1, d);
    end
    chk("lock_after_rst", 32'(locked), 32'd1);

    // Runs of 15 tokens never lock; offset walks and wraps
    skew = 0;
    do_reset();
    for (int n = 0; n < 20490; n++) begin
      if (n == 2047)  chk("off_pre1", 32'(bit_offset), 32'd0);
      if (n == 2048)  chk("off_1", 32'(bit_offset), 32'd1);
      if (n == 20479) chk("off_9", 32'(bit_offset), 32'd9);
      if (n == 20480) chk("off_wrap", 32'(bit_offset), 32'd0);
      if ((n % 16) < 15) step(T0, 1'b0, 8'h00);
      else               step(D00, 1'b0, 8'h00);
    end
    chk("never_lock", 32'(locked), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tmds_decoder.md
Name: tmds_decoder

Overview:
- Receive-side TMDS channel decoder; the inverse of the transmit-side TMDS encoder.
- Sits after a 1:10 deserializer in the pixel-clock domain and accepts one unaligned 10-bit word per clock.
- Finds the symbol boundary by searching for runs of control tokens, then decodes aligned symbols into 8-bit pixel data or 2-bit control values plus a data-enable.
- One instance per channel (blue carries hsync/vsync on c).

Parameters:
- LOCK_COUNT, 16: consecutive control tokens required to declare lock.
- SEARCH_WINDOW, 2048: clocks spent at one bit offset before advancing; must exceed one video line (800).
- LOSS_TIMEOUT, 4096: clocks with no control token while locked before lock is dropped.
- CNT_W, 13: width of the internal run and timeout counters; must hold max(SEARCH_WINDOW, LOSS_TIMEOUT).

Ports:
- clk, input, 1: pixel clock.
- reset, input, 1: asynchronous, active-high.
- raw_in, input, 10: deserialized word; bit 0 is the earliest-received bit.
- data, output, 8: decoded pixel byte.
- c, output, 2: decoded control bits {c1,c0}.
- de, output, 1: 1 = data symbol, 0 = control token.
- locked, output, 1: alignment locked.
- bit_offset, output, 4: current alignment offset, 0..9.

Behaviour:
- Reset (async, active-high): all outputs 0, state SEARCH, bit_offset 0, raw_d1 0, all counters 0. Outputs go to 0 immediately on assertion, including mid-lock.
- Alignment window:
  - raw_d1 holds the previous raw_in.
  - w = {raw_in, raw_d1} (20 bits).
  - Aligned symbol = w[bit_offset+9 : bit_offset], registered into sym_q each clock.
- Latency: a symbol starting at raw_in[bit_offset] on edge k (completed by raw_in[bit_offset-1:0] on edge k+1 when bit_offset > 0) appears on data/c/de after edge k+2, for every offset.
- Token detect on sym_q:
  - 1101010100 -> c=00
  - 0010101011 -> c=01
  - 0101010100 -> c=10
  - 1010101011 -> c=11
- Data decode:
  - d = sym[9] ? ~sym[7:0] : sym[7:0].
  - out[0] = d[0].
  - For i = 1..7: sym[8]=1 gives out[i] = d[i]^d[i-1]; sym[8]=0 gives out[i] = ~(d[i]^d[i-1]).
- Output register (only while locked):
  - Token: de=0, c=token value, data holds its previous value.
  - Non-token: de=1, data=out, c holds its previous value.
- While not locked: de=0, c=00, data=00.
- FSM SEARCH:
  - tok_run increments when sym_q is a token and clears otherwise.
  - win_cnt increments every clock.
  - If tok_run reaches LOCK_COUNT: go to LOCKED; locked=1 from the next clock; bit_offset frozen.
  - Else if win_cnt reaches SEARCH_WINDOW-1: bit_offset = (bit_offset==9) ? 0 : bit_offset+1, clear both counters, and ignore sym_q for the next 1 clock (pipeline holdoff).
  - Lock wins if both conditions hit in the same cycle.
- FSM LOCKED:
  - gap_cnt clears on any token and increments otherwise.
  - If gap_cnt reaches LOSS_TIMEOUT: go to SEARCH with locked=0 next clock, bit_offset unchanged (retry current offset first), counters cleared.
  - Data decode is never an error source; only token absence drops lock.
- Counters saturate; no wrap.

Test Plan:
- Reset then stream at offset 0: 160 × 1101010100, then 0100000000, then 1000000000 -> locked=1 after the 16th token + 1 clock; bit_offset=0; de=1 with data=0x00, then 0xFF; c=00 during tokens.
- Same stream with a 3-bit skew (every word prefixed by 3 bits from the previous word) and 800-clock lines containing 160-token blanking -> offsets 0,1,2 each time out after 2048 clocks; lock at bit_offset=3; decoded data matches the unskewed case.
- Locked on the blue channel; inject tokens 0010101011, 0101010100, 1010101011 -> c=01, 10, 11 with de=0, 2 clocks after presentation.
- Locked, then data-only symbols for 4096 clocks -> locked falls to 0 and outputs force to 0; tokens resumed -> relock at the same bit_offset.
- Assert reset asynchronously mid-line while locked -> data/c/de/locked/bit_offset all 0 immediately, without waiting for a clock edge; after release, relock occurs.
- Exactly 15 tokens then data, repeated -> never locks; bit_offset advances 0->1 at clock 2048 and wraps 9->0 after 10 windows.
